// File: rtl/unidade_mult_div.sv
// Iterative 32-bit multiply/divide unit: one radix-2 step per clock.
// Shift-add multiply and restoring divide on magnitudes, with the sign fixed up in a final step.
module unidade_mult_div (
   input  logic        clock,
   input  logic        reset,
   input  logic        inicio,
   input  logic [1:0]  operacao,
   input  logic [31:0] operandoA,
   input  logic [31:0] operandoB,
   output logic        ocupado,
   output logic        pronto,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        divPorZero
);

   typedef enum logic [1:0] {OCIOSO, CALCULA, AJUSTE} estado_t;

   estado_t     estado_q, estado_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        eh_div_q, eh_div_d;
   logic        neg_a_q, neg_a_d;
   logic        neg_b_q, neg_b_d;
   logic        b_zero_q, b_zero_d;
   logic [31:0] mag_q, mag_d;
   logic [31:0] a_raw_q, a_raw_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        pronto_q, pronto_d;
   logic        ocupado_q, ocupado_d;
   logic        dz_q, dz_d;

   logic        com_sinal;
   logic [31:0] mag_a, mag_b;
   logic [32:0] soma;
   logic [32:0] tentativa;
   logic [32:0] dif;
   logic [63:0] acc_mul, acc_div;
   logic [63:0] produto;
   logic [31:0] quociente, resto;

   always_comb begin
      com_sinal = ~operacao[0];
      mag_a     = (com_sinal && operandoA[31]) ? -operandoA : operandoA;
      mag_b     = (com_sinal && operandoB[31]) ? -operandoB : operandoB;

      // Multiply: conditionally add the multiplicand into the upper half, then shift right.
      soma      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
      acc_mul   = {soma, acc_q[31:1]};

      // Divide: shift in the next dividend bit; a borrow out of bit 32 means restore.
      tentativa = {acc_q[63:32], acc_q[31]};
      dif       = tentativa - {1'b0, mag_q};
      acc_div   = dif[32] ? {tentativa[31:0], acc_q[30:0], 1'b0}
                          : {dif[31:0], acc_q[30:0], 1'b1};

      produto   = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
      quociente = (neg_a_q ^ neg_b_q) ? -acc_q[31:0] : acc_q[31:0];
      resto     = neg_a_q ? -acc_q[63:32] : acc_q[63:32];

      estado_d  = estado_q;
      cnt_d     = cnt_q;
      eh_div_d  = eh_div_q;
      neg_a_d   = neg_a_q;
      neg_b_d   = neg_b_q;
      b_zero_d  = b_zero_q;
      mag_d     = mag_q;
      a_raw_d   = a_raw_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      ocupado_d = ocupado_q;
      pronto_d  = 1'b0;
      dz_d      = 1'b0;

      case (estado_q)
         OCIOSO: begin
            if (inicio) begin
               eh_div_d  = operacao[1];
               neg_a_d   = com_sinal & operandoA[31];
               neg_b_d   = com_sinal & operandoB[31];
               b_zero_d  = (operandoB == 32'd0);
               a_raw_d   = operandoA;
               mag_d     = operacao[1] ? mag_b : mag_a;
               acc_d     = {32'd0, operacao[1] ? mag_a : mag_b};
               cnt_d     = 5'd31;
               ocupado_d = 1'b1;
               estado_d  = CALCULA;
            end
         end
         CALCULA: begin
            acc_d = eh_div_q ? acc_div : acc_mul;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
               estado_d = AJUSTE;
            end
         end
         AJUSTE: begin
            if (!eh_div_q) begin
               hi_d = produto[63:32];
               lo_d = produto[31:0];
            end else if (b_zero_q) begin
               hi_d = a_raw_q;
               lo_d = 32'hFFFF_FFFF;
               dz_d = 1'b1;
            end else begin
               hi_d = resto;
               lo_d = quociente;
            end
            pronto_d  = 1'b1;
            ocupado_d = 1'b0;
            estado_d  = OCIOSO;
         end
         default: begin
            estado_d  = OCIOSO;
            ocupado_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q  <= OCIOSO;
         cnt_q     <= '0;
         eh_div_q  <= 1'b0;
         neg_a_q   <= 1'b0;
         neg_b_q   <= 1'b0;
         b_zero_q  <= 1'b0;
         mag_q     <= '0;
         a_raw_q   <= '0;
         acc_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pronto_q  <= 1'b0;
         ocupado_q <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         cnt_q     <= cnt_d;
         eh_div_q  <= eh_div_d;
         neg_a_q   <= neg_a_d;
         neg_b_q   <= neg_b_d;
         b_zero_q  <= b_zero_d;
         mag_q     <= mag_d;
         a_raw_q   <= a_raw_d;
         acc_q     <= acc_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pronto_q  <= pronto_d;
         ocupado_q <= ocupado_d;
         dz_q      <= dz_d;
      end
   end

   assign ocupado    = ocupado_q;
   assign pronto     = pronto_q;
   assign hi         = hi_q;
   assign lo         = lo_q;
   assign divPorZero = dz_q;

endmodule

// File: tb/tb_unidade_mult_div.sv
// Directed bench for unidade_mult_div: known products/quotients, latency, busy handling and reset abort.
module tb_unidade_mult_div;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        inicio = 1'b0;
   logic [1:0]  operacao = 2'b00;
   logic [31:0] operandoA = '0;
   logic [31:0] operandoB = '0;
   logic        ocupado, pronto, divPorZero;
   logic [31:0] hi, lo;

   int checks = 0;
   int failures = 0;

   unidade_mult_div dut (
      .clock(clock), .reset(reset), .inicio(inicio), .operacao(operacao),
      .operandoA(operandoA), .operandoB(operandoB), .ocupado(ocupado),
      .pronto(pronto), .hi(hi), .lo(lo), .divPorZero(divPorZero)
   );

   always #5 clock = ~clock;

   // Issue one operation, scramble the operand inputs after acceptance, and wait for pronto.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] rh, output logic [31:0] rl,
                         output logic rdz, output int busy_err);
      @(negedge clock);
      inicio = 1'b1; operacao = op; operandoA = a; operandoB = b;
      @(negedge clock);
      inicio = 1'b0; operacao = ~op; operandoA = $urandom; operandoB = $urandom;
      lat = -1; busy_err = 0; rh = '0; rl = '0; rdz = 1'b0;
      if (!ocupado) busy_err++;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         if (pronto) begin
            lat = n; rh = hi; rl = lo; rdz = divPorZero;
            if (ocupado) busy_err++;
            break;
         end
         if (!ocupado) busy_err++;
         if (divPorZero) busy_err++;
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({ocupado, pronto, divPorZero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_state: ocupado=%b pronto=%b dz=%b hi=%h lo=%h, required all zero",
                  ocupado, pronto, divPorZero, hi, lo);
      end
      @(negedge clock); reset = 1'b1;
      $display("reset released");
   endtask

   task automatic test_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz);
      int lat, berr;
      logic [31:0] rh, rl;
      logic rdz;
      run_op(op, a, b, lat, rh, rl, rdz, berr);
      $display("op %s a=%h b=%h -> lat=%0d hi=%h lo=%h dz=%b", name, a, b, lat, rh, rl, rdz);
      checks++;
      if (lat !== 33) begin
         failures++;
         $display("FAIL %s_latency: got %0d cycles, required 33", name, lat);
      end
      checks++;
      if (rh !== exp_hi || rl !== exp_lo) begin
         failures++;
         $display("FAIL %s_result: hi=%h lo=%h, required hi=%h lo=%h", name, rh, rl, exp_hi, exp_lo);
      end
      checks++;
      if (rdz !== exp_dz || berr != 0) begin
         failures++;
         $display("FAIL %s_flags: dz=%b busy_errors=%0d, required dz=%b busy_errors=0",
                  name, rdz, berr, exp_dz);
      end
      @(negedge clock);
      checks++;
      if (pronto !== 1'b0 || divPorZero !== 1'b0) begin
         failures++;
         $display("FAIL %s_pulse: pronto=%b dz=%b one cycle later, required 0 0", name, pronto, divPorZero);
      end
   endtask

   task automatic test_hold();
      logic [31:0] h0, l0;
      h0 = hi; l0 = lo;
      operandoA = 32'h1234_5678; operandoB = 32'h9abc_def0;
      repeat (5) @(negedge clock);
      checks++;
      if (hi !== 32'h0000_0064 || lo !== 32'hFFFF_FFFF || hi !== h0 || lo !== l0) begin
         failures++;
         $display("FAIL hold: hi=%h lo=%h, required hi=00000064 lo=ffffffff", hi, lo);
      end
      $display("hold hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_back_to_back();
      int n, c, prontos;
      // First op: MULT 7 x -3, accepted at E0.
      @(negedge clock);
      inicio = 1'b1; operacao = 2'b00; operandoA = 32'h7; operandoB = 32'hFFFF_FFFD;
      @(negedge clock);
      inicio = 1'b0; operandoA = 32'h5555_5555; operandoB = 32'h2;
      repeat (4) @(negedge clock);
      inicio = 1'b1; operacao = 2'b01; operandoA = 32'hFFFF_FFFF; operandoB = 32'hFFFF_FFFF;
      @(negedge clock);
      inicio = 1'b0;
      n = 5; prontos = 0;
      while (n < 45 && !pronto) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (n !== 33 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
         failures++;
         $display("FAIL busy_ignore: pronto after %0d hi=%h lo=%h, required 33 ffffffff ffffffeb", n, hi, lo);
      end
      $display("busy op done n=%0d hi=%h lo=%h", n, hi, lo);
      // Start DIVU 100/7 in the pronto cycle.
      inicio = 1'b1; operacao = 2'b11; operandoA = 32'd100; operandoB = 32'd7;
      @(negedge clock);
      inicio = 1'b0; operandoA = 32'd0; operandoB = 32'd0;
      c = 1;
      checks++;
      if (pronto !== 1'b0 || ocupado !== 1'b1) begin
         failures++;
         $display("FAIL b2b_accept: pronto=%b ocupado=%b, required 0 1", pronto, ocupado);
      end
      while (c < 45 && !pronto) begin
         @(negedge clock);
         c++;
      end
      checks++;
      if (c !== 34) begin
         failures++;
         $display("FAIL b2b_spacing: %0d cycles between prontos, required 34", c);
      end
      checks++;
      if (hi !== 32'd2 || lo !== 32'd14) begin
         failures++;
         $display("FAIL b2b_result: hi=%h lo=%h, required 00000002 0000000e", hi, lo);
      end
      $display("back-to-back spacing=%0d hi=%h lo=%h", c, hi, lo);
   endtask

   task automatic test_reset_mid();
      int prontos;
      @(negedge clock);
      inicio = 1'b1; operacao = 2'b00; operandoA = 32'h7; operandoB = 32'h9;
      @(negedge clock);
      inicio = 1'b0;
      repeat (9) @(negedge clock);
      @(posedge clock);
      #1 reset = 1'b0;
      #1;
      checks++;
      if (ocupado !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_mid: ocupado=%b hi=%h lo=%h, required 0 0 0", ocupado, hi, lo);
      end
      @(negedge clock); reset = 1'b1;
      prontos = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (pronto) prontos++;
      end
      checks++;
      if (prontos != 0 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_abort: prontos=%0d hi=%h lo=%h, required 0 0 0", prontos, hi, lo);
      end
      $display("reset mid-op: prontos=%0d", prontos);
   endtask

   initial begin
      test_reset();
      test_op("mult_neg",   2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      test_op("mult_negneg",2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E, 1'b0);
      test_op("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      test_op("div_negdvd", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      test_op("div_negdvs", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
      test_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
      test_op("divu",       2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
      test_op("div_zero",   2'b10, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
      test_op("divu_zero",  2'b11, 32'h0000_0064, 32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
      test_hold();
      test_back_to_back();
      test_reset_mid();
      test_op("after_reset",2'b01, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
